// File: rtl/iterative_alu.sv
// Execute unit for the 4-bit ALU decoder code: logic/arith/compare ops, plus serial shifts at 1 bit per cycle.
// Latency: 1 cycle for non-shift, illegal, and zero-amount shift ops; N+1 cycles for a shift by N > 0.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready (1 bubble between ops).
module iterative_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal_op,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shop_t;

    state_t           state, state_nxt;
    shop_t            sh_op, dec_sh;
    logic [WIDTH-1:0] work, work_nxt;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] dec_res;
    logic             dec_ill;
    logic             dec_shift;
    logic             accept;
    logic             last_shift;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state == SHIFT);
    assign accept     = in_valid && in_ready;
    assign shamt      = SrcB[SHW-1:0];
    assign last_shift = (state == SHIFT) && (cnt == CNT_ONE);

    // Op decode; an X on ALUControl matches no item and falls into the illegal default.
    always_comb begin
        dec_res   = '0;
        dec_ill   = 1'b0;
        dec_shift = 1'b0;
        dec_sh    = SH_SLL;
        case (ALUControl)
            4'b0000: dec_res = SrcA + SrcB;
            4'b0001: dec_res = SrcA - SrcB;
            4'b0010: dec_res = SrcA & SrcB;
            4'b0011: dec_res = SrcA | SrcB;
            4'b0100: dec_res = SrcA ^ SrcB;
            4'b0101: dec_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            4'b0110: begin dec_shift = 1'b1; dec_sh = SH_SRA; dec_res = SrcA; end
            4'b0111: begin dec_shift = 1'b1; dec_sh = SH_SRL; dec_res = SrcA; end
            4'b1000: begin dec_shift = 1'b1; dec_sh = SH_SLL; dec_res = SrcA; end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        work_nxt = work;
        case (sh_op)
            SH_SLL:  work_nxt = {work[WIDTH-2:0], 1'b0};
            SH_SRL:  work_nxt = {1'b0, work[WIDTH-1:1]};
            SH_SRA:  work_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
            default: work_nxt = work;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (dec_shift && (shamt != '0)) ? SHIFT : DONE;
            SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output registers move only on accept or on the final shift step, so DONE holds them stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUResult  <= '0;
            Zero       <= 1'b0;
            illegal_op <= 1'b0;
            work       <= '0;
            cnt        <= '0;
            sh_op      <= SH_SLL;
        end else if (accept) begin
            work       <= SrcA;
            cnt        <= shamt;
            sh_op      <= dec_sh;
            illegal_op <= dec_ill;
            if (!(dec_shift && (shamt != '0))) begin
                ALUResult <= dec_res;
                Zero      <= (dec_res == '0);
            end
        end else if (state == SHIFT) begin
            work <= work_nxt;
            cnt  <= cnt - CNT_ONE;
            if (last_shift) begin
                ALUResult <= work_nxt;
                Zero      <= (work_nxt == '0);
            end
        end
    end
endmodule

// File: tb/tb_iterative_alu.sv
// Table-driven and randomized checks of iterative_alu against a plain-arithmetic reference model.
module tb_iterative_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal_op;
    logic        busy;

    int checks = 0;
    int errors = 0;

    iterative_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: whole-word shifts and arithmetic, latency derived from the shift amount.
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic ill, output int lat);
        logic [4:0] n;
        n   = b[4:0];
        lat = 1;
        ill = 1'b0;
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: begin r = $signed(a) >>> n; lat = int'(n) + 1; end
            4'd7: begin r = a >> n;           lat = int'(n) + 1; end
            4'd8: begin r = a << n;           lat = int'(n) + 1; end
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        z = (r == 32'd0);
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez,
                          input logic ei, input int elat);
        int cyc;
        chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        ALUControl = c;
        SrcA       = a;
        SrcB       = b;
        @(negedge clk);
        in_valid   = 1'b0;
        SrcA       = ~a;
        SrcB       = ~b;
        cyc = 1;
        if (elat > 1) begin
            chk({name, ".busy"}, {31'd0, busy}, 32'd1);
            chk({name, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        end
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, ".latency"}, cyc, elat);
        chk({name, ".result"}, ALUResult, er);
        chk({name, ".zero"}, {31'd0, Zero}, {31'd0, ez});
        chk({name, ".illegal"}, {31'd0, illegal_op}, {31'd0, ei});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        z;
        logic        il;
        int          lat;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0]  = '{"add_wrap", 4'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1};
        tbl[1]  = '{"sub",      4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 1};
        tbl[2]  = '{"slt_neg",  4'd5,  32'h80000000, 32'h1,        32'h1,        1'b0, 1'b0, 1};
        tbl[3]  = '{"and",      4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1};
        tbl[4]  = '{"sra31",    4'd6,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 32};
        tbl[5]  = '{"srl4",     4'd7,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 5};
        tbl[6]  = '{"sll0",     4'd8,  32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0, 1};
        tbl[7]  = '{"illegal",  4'hB,  32'h1234,     32'h5678,     32'h0,        1'b1, 1'b1, 1};
        tbl[8]  = '{"add_clr",  4'd0,  32'd2,        32'd3,        32'd5,        1'b0, 1'b0, 1};
        tbl[9]  = '{"or",       4'd3,  32'h0F00,     32'h00F0,     32'h0FF0,     1'b0, 1'b0, 1};
        tbl[10] = '{"xor",      4'd4,  32'hFF,       32'h0F,       32'hF0,       1'b0, 1'b0, 1};
        tbl[11] = '{"sll_mask", 4'd8,  32'h1,        32'h21,       32'h2,        1'b0, 1'b0, 2};
        tbl[12] = '{"slt_pos",  4'd5,  32'h1,        32'h80000000, 32'h0,        1'b1, 1'b0, 1};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUControl = 4'd0; SrcA = 32'd0; SrcB = 32'd0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", ALUResult, 32'd0);
        chk("rst.zero", {31'd0, Zero}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.illegal", {31'd0, illegal_op}, 32'd0);

        for (int i = 0; i < 13; i++)
            run_op(tbl[i].name, tbl[i].ctrl, tbl[i].a, tbl[i].b,
                   tbl[i].res, tbl[i].zero, tbl[i].ill, tbl[i].lat);

        // Result held under backpressure while a competing op is offered.
        in_valid = 1'b1; ALUControl = 4'd0; SrcA = 32'h10; SrcB = 32'h20;
        @(negedge clk);
        ALUControl = 4'd1; SrcA = 32'h99; SrcB = 32'h1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp.hold%0d.valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp.hold%0d.result", k), ALUResult, 32'h30);
            chk($sformatf("bp.hold%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.drop", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("bp.single", {31'd0, out_valid}, 32'd0);
        chk("bp.kept", ALUResult, 32'h30);

        // Asynchronous reset in the middle of a 20-step sll.
        in_valid = 1'b1; ALUControl = 4'd8; SrcA = 32'h1; SrcB = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst.result", ALUResult, 32'd0);
        chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("post_rst", 4'd0, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            c = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) b = a;
            model(c, a, b, r, z, il, lat);
            run_op($sformatf("rand%0d", i), c, a, b, r, z, il, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
